// File: rtl/systolic_pkg.sv
// Shared types and constants for the 4x4 systolic operand feeder.
package systolic_pkg;

  localparam int unsigned N          = 4;
  localparam int unsigned FEED_STEPS = 2 * N - 1;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    FEED,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/systolic_feeder_skew_lane.sv
// One skewed stream lane: selects element (step - LANE) of a stored row/column, or 0 outside the window.
module skew_lane
  import systolic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LANE       = 0
) (
  input  logic                      en_i,
  input  logic [2:0]                step_i,
  input  logic [N*DATA_WIDTH-1:0]   vec_i,
  output logic [DATA_WIDTH-1:0]     elem_o
);

  logic [3:0] diff;

  always_comb begin
    elem_o = '0;
    diff   = {1'b0, step_i} - 4'(LANE);
    // diff in 0..3 exactly when both the sign bit and bit 2 are clear
    if (en_i && (diff[3:2] == 2'b00)) begin
      for (int unsigned k = 0; k < N; k++) begin
        if (diff[1:0] == 2'(k)) elem_o = vec_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Operand buffer and skewed stream generator for the 4x4 systolic multiplier.
// Optional macro FEEDER_TRANSPOSE_B_EN: top streams read B transposed (array computes A*B^T).
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic                  wr_sel_i,
  input  logic [3:0]            wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  array_clr_o,
  output logic [DATA_WIDTH-1:0] left_o_0,
  output logic [DATA_WIDTH-1:0] left_o_4,
  output logic [DATA_WIDTH-1:0] left_o_8,
  output logic [DATA_WIDTH-1:0] left_o_12,
  output logic [DATA_WIDTH-1:0] up_o_0,
  output logic [DATA_WIDTH-1:0] up_o_1,
  output logic [DATA_WIDTH-1:0] up_o_2,
  output logic [DATA_WIDTH-1:0] up_o_3,
  output logic                  done_o
);

  state_e                  state_q, state_d;
  logic [2:0]              step_q, step_d;
  logic [3:0]              drain_q, drain_d;
  logic [DATA_WIDTH-1:0]   a_q [N*N];
  logic [DATA_WIDTH-1:0]   b_q [N*N];
  logic [DATA_WIDTH-1:0]   left_q [N];
  logic [DATA_WIDTH-1:0]   up_q [N];
  logic [DATA_WIDTH-1:0]   left_d [N];
  logic [DATA_WIDTH-1:0]   up_d [N];
  logic [N*DATA_WIDTH-1:0] a_row [N];
  logic [N*DATA_WIDTH-1:0] b_vec [N];
  logic                    feed_d;
  logic                    wr_en;

  assign wr_ready_o  = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign array_clr_o = (state_q == CLR);
  assign done_o      = (state_q == DONE);
  assign wr_en       = wr_valid_i && wr_ready_o;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    drain_d = drain_q;
    unique case (state_q)
      IDLE:  if (start_i) state_d = CLR;
      CLR: begin
        state_d = FEED;
        step_d  = '0;
      end
      FEED: begin
        if (step_q == 3'(FEED_STEPS - 1)) begin
          state_d = DRAIN;
          drain_d = '0;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      DRAIN: begin
        if (drain_q == 4'(DRAIN_CYCLES - 1)) state_d = DONE;
        else drain_d = drain_q + 4'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Lanes look at the next state/step so stream registers line up with the FEED cycle they belong to.
  assign feed_d = (state_d == FEED);

  for (genvar g = 0; g < N; g++) begin : g_lane
    for (genvar k = 0; k < N; k++) begin : g_el
      assign a_row[g][k*DATA_WIDTH +: DATA_WIDTH] = a_q[g*N + k];
`ifdef FEEDER_TRANSPOSE_B_EN
      assign b_vec[g][k*DATA_WIDTH +: DATA_WIDTH] = b_q[g*N + k];
`else
      assign b_vec[g][k*DATA_WIDTH +: DATA_WIDTH] = b_q[k*N + g];
`endif
    end

    skew_lane #(.DATA_WIDTH(DATA_WIDTH), .LANE(g)) u_left (
      .en_i   (feed_d),
      .step_i (step_d),
      .vec_i  (a_row[g]),
      .elem_o (left_d[g])
    );

    skew_lane #(.DATA_WIDTH(DATA_WIDTH), .LANE(g)) u_up (
      .en_i   (feed_d),
      .step_i (step_d),
      .vec_i  (b_vec[g]),
      .elem_o (up_d[g])
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      step_q  <= '0;
      drain_q <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        left_q[i] <= '0;
        up_q[i]   <= '0;
      end
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      drain_q <= drain_d;
      for (int unsigned i = 0; i < N; i++) begin
        left_q[i] <= left_d[i];
        up_q[i]   <= up_d[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < N*N; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
    end else if (wr_en) begin
      if (wr_sel_i == SEL_A) a_q[wr_addr_i] <= wr_data_i;
      else                   b_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign left_o_0  = left_q[0];
  assign left_o_4  = left_q[1];
  assign left_o_8  = left_q[2];
  assign left_o_12 = left_q[3];
  assign up_o_0    = up_q[0];
  assign up_o_1    = up_q[1];
  assign up_o_2    = up_q[2];
  assign up_o_3    = up_q[3];

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Upstream stage of the 4x4 systolic multiplier.
- Buffers one 4x4 operand matrix A and one 4x4 operand matrix B, both loaded element-by-element.
- On start, drives the array's four left inputs and four top inputs with diagonally skewed, zero-padded streams, then drains and flags completion.
- Also generates the array-clear pulse. Top level inverts it onto the array's active-low reset so accumulators start from zero.

Parameters:
- DATA_WIDTH, 32, element width of A, B and every stream output.
- DRAIN_CYCLES, 4, zero-feed cycles after the last skewed element before done_o; legal range 1..15.

Ports:
- clk_i  input  1  clock, all logic on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- wr_valid_i  input  1  element write request.
- wr_ready_o  output  1  write accepted when wr_valid_i & wr_ready_o.
- wr_sel_i  input  1  0 = matrix A, 1 = matrix B.
- wr_addr_i  input  4  element index, row-major: row = addr[3:2], col = addr[1:0].
- wr_data_i  input  DATA_WIDTH  element value.
- start_i  input  1  begin a feed sequence (sampled in IDLE only).
- busy_o  output  1  high in every state except IDLE.
- array_clr_o  output  1  one-cycle array clear pulse.
- left_o_0, left_o_4, left_o_8, left_o_12  output  DATA_WIDTH each  array left inputs, rows 0..3.
- up_o_0, up_o_1, up_o_2, up_o_3  output  DATA_WIDTH each  array top inputs, cols 0..3.
- done_o  output  1  one-cycle completion pulse.

Behaviour:
- Reset (rst_i high at a clock edge), from any state:
  - state goes to IDLE; both matrices cleared to 0;
  - all stream outputs 0; array_clr_o = 0, done_o = 0, busy_o = 0, wr_ready_o = 1.
  - A mid-sequence reset aborts it: no done_o is produced.
- States: IDLE -> CLR -> FEED -> DRAIN -> DONE -> IDLE.
- IDLE:
  - wr_ready_o = 1; an accepted write updates the selected element on the edge.
  - Rewriting the same element is allowed; last write wins.
  - start_i = 1 moves to CLR.
  - If a write and start_i occur in the same cycle, the write commits, then the feed uses the updated matrix.
- CLR: one cycle; array_clr_o = 1, streams = 0.
- FEED: 7 cycles, step t = 0..6 (3-bit counter).
  - left_o_(4r) = A[r][t-r] when 0 <= t-r <= 3, else 0.
  - up_o_c = B[t-c][c] when 0 <= t-c <= 3, else 0.
- DRAIN: DRAIN_CYCLES cycles, streams = 0.
- DONE: one cycle, done_o = 1, streams = 0; then IDLE.
- Outputs are registered: the values for step t are visible during the cycle the state is FEED with counter = t.
- Latency: start accepted at edge k -> array_clr_o high in cycle k+1 -> step 0 at k+2 -> done_o at k+9+DRAIN_CYCLES (k+13 by default).
- Outside IDLE: wr_ready_o = 0, writes are ignored, start_i is ignored.
- Stored matrices persist across sequences; back-to-back starts reuse them.
- No arithmetic is performed on data; elements pass through bit-exact.

Optional Feature:
- Macro FEEDER_TRANSPOSE_B_EN.
- Defined: top streams read B transposed, up_o_c = B[c][t-c] with the same validity window. The array then computes A*B^T, so row-major-stored weights need no software transpose.
- Undefined: normal B[t-c][c] order; no transpose muxing is synthesized.

Decomposition:
- Shared package systolic_pkg holds:
  - state enum (IDLE, CLR, FEED, DRAIN, DONE);
  - constants N = 4, FEED_STEPS = 2*N-1 = 7;
  - matrix select encodings SEL_A = 0, SEL_B = 1.
- One sub-module, skew_lane: given a step count, lane index and one stored row/column, it outputs the windowed element or 0. Instantiate 4 for A rows and 4 for B columns.

Test Plan:
- Reset mid-FEED (step 3) -> next cycle: all streams 0, busy_o = 0, no done_o; subsequent reads of A/B give 0 (streams all 0 on the next start).
- Load A[i] = i+1 and B[i] = 16+i (i = 0..15), pulse start -> step 0: left_o_0 = 1, up_o_0 = 16, others 0; step 3: left_o_12 = 13, up_o_3 = 19; step 6: left_o_12 = 16, up_o_3 = 31, others 0; done_o exactly 13 cycles after start accepted.
- Identity A with B as above, through the real array -> array results equal B; array_clr_o high exactly one cycle before step 0.
- Write A[5] = 7 and start_i in the same IDLE cycle -> step 2 shows left_o_4 = 7; a write attempted during FEED leaves the stored value unchanged (next run shows the old value).
- start_i held high continuously -> sequences repeat every 9+DRAIN_CYCLES+1 cycles with an IDLE cycle between; no start is taken during busy.
- FEEDER_TRANSPOSE_B_EN defined with B as above -> step 1: up_o_1 = B[1][0] = 20; step 3: up_o_0 = B[0][3] = 19.
